// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
//
// Sequential radix-4 (modified) Booth multiplier. It retires two multiplier
// bits per clock and handles signed or unsigned operands, chosen per
// operation. A start/busy/done handshake lets a controlling FSM issue an
// operation and wait for the result.
//
// Parameters:
//   N    operand width in bits (even, >= 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a new multiplication (taken only when not busy)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier (sampled with start)
//   busy         high while iterating
//   done         one-cycle pulse when prod becomes valid
//   prod         2N-bit product, held until the next result is produced
//
// Optional build macro:
//   BOOTH_EARLY_TERM_EN  finish as soon as the unconsumed multiplier bits are
//                        all copies of the last consumed bit (all remaining
//                        Booth digits are zero). prod is unchanged; only the
//                        latency shrinks.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  // Number of radix-4 steps over the (N+2)-bit extended multiplier.
  localparam int ITER = N/2 + 1;
  // Extended operand width: one bit to make unsigned values non-negative
  // in two's complement, plus one to pad the multiplier to an even width.
  localparam int XW   = N + 2;
  // Accumulator = upper partial-sum half plus the shifting multiplier half.
  localparam int AW   = 2*XW;
  localparam int CW   = $clog2(ITER + 1);

  if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
    $error("booth_radix4_multiplier: N must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [XW-1:0]  mcand_reg;   // extended multiplicand
  logic [XW-1:0]  hi_reg;      // upper accumulator half
  logic [XW-1:0]  mul_reg;     // remaining multiplier bits (low half)
  logic           ref_reg;     // Booth reference bit (b[2k-1])
  logic [CW-1:0]  cnt_reg;
  logic [2*N-1:0] prod_reg;

  logic           accept;
  logic           last_iter;
  logic           finish_calc;
  logic [XW-1:0]  a_ext;
  logic [XW-1:0]  b_ext;
  logic [XW-1:0]  addend;
  logic [XW-1:0]  hi_sum;
  logic signed [AW-1:0] acc_next;
  logic [2*N-1:0] prod_load;

  // Operand extension for capture.
  always_comb begin
    a_ext = signed_mode ? {{2{a[N-1]}}, a} : {2'b00, a};
    b_ext = signed_mode ? {{2{b[N-1]}}, b} : {2'b00, b};
  end

  // Booth recoding of {b[2k+1], b[2k], b[2k-1]} into a multiple of the
  // multiplicand. The upper half has one bit of headroom over N+1 bits,
  // so +-2a and the running sum never overflow it.
  always_comb begin
    addend = '0;
    unique case ({mul_reg[1:0], ref_reg})
      3'b001, 3'b010: addend = mcand_reg;
      3'b011:         addend = {mcand_reg[XW-2:0], 1'b0};
      3'b100:         addend = -{mcand_reg[XW-2:0], 1'b0};
      3'b101, 3'b110: addend = -mcand_reg;
      default:        addend = '0;
    endcase
  end

  always_comb begin
    hi_sum    = hi_reg + addend;
    acc_next  = $signed({hi_sum, mul_reg}) >>> 2;
    last_iter = (cnt_reg == CW'(ITER - 1));
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [CW:0]          cnt_x2;
  logic [CW:0]          shamt;
  logic [XW-1:0]        rem_mask;
  logic                 early_hit;
  logic signed [AW-1:0] acc_aligned;

  always_comb begin
    cnt_x2 = {cnt_reg, 1'b0};
    // After this step the low N-2k bits of the shifted multiplier half are
    // the bits not yet consumed.
    rem_mask = {XW{1'b1}} >> (cnt_x2 + (CW+1)'(2));
    // All remaining bits equal the last consumed bit -> every remaining
    // digit recodes to zero, so the sum is already final.
    early_hit = (((acc_next[XW-1:0] ^ {XW{mul_reg[1]}}) & rem_mask) == '0);
    // Apply the shifts the skipped steps would have done.
    shamt       = (CW+1)'(2*(ITER - 1)) - cnt_x2;
    acc_aligned = acc_next >>> shamt;
    finish_calc = last_iter | early_hit;
    prod_load   = acc_aligned[2*N-1:0];
  end
`else
  always_comb begin
    finish_calc = last_iter;
    prod_load   = acc_next[2*N-1:0];
  end
`endif

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state and decoded outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (finish_calc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        accept     = start;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg <= '0;
      hi_reg    <= '0;
      mul_reg   <= '0;
      ref_reg   <= 1'b0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
    end else if (accept) begin
      mcand_reg <= a_ext;
      hi_reg    <= '0;
      mul_reg   <= b_ext;
      ref_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (busy) begin
      {hi_reg, mul_reg} <= acc_next;
      ref_reg           <= mul_reg[1];
      cnt_reg           <= cnt_reg + CW'(1);
      if (finish_calc) begin
        prod_reg <= prod_load;
      end
    end
  end

  assign prod = prod_reg;

endmodule
